hv_dac_slave: RTL
=================

HV_DAC_SLAVE -- requirements
Module: hv_dac_slave

Interface
REQ-001 SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-002 SHALL have: clk  input  1  system clock; frequency >= 4x dac_sclk.
REQ-003 SHALL have: dac_sel  input  1  active-low frame select from the DAC master.
REQ-004 SHALL have: dac_sclk  input  1  serial clock; idles high while dac_sel is high.
REQ-005 SHALL have: dac_din  input  1  serial data, MSB first; master changes it on the dac_sclk rising edge.
REQ-006 SHALL have: dac_dout  output  1  readback/echo serial data to the master.
REQ-007 SHALL have: ch_value  output  80  8 channels x 10 bits; channel n is at [10n+9:10n].
REQ-008 SHALL have: frame_done  output  1  one-clk pulse when a 16-bit frame is accepted.
REQ-009 SHALL have: frame_err  output  1  one-clk pulse when a frame closes with a bit count other than 16.
REQ-010 SHALL have: last_cmd  output  4  command nibble of the last accepted frame.

Function
REQ-011 SHALL synchronise dac_sel, dac_sclk and dac_din through 2-FF synchronisers, then detect sclk rise, sclk fall and sel rise/fall in the clk domain.
REQ-012 SHALL implement the FSM IDLE -> SHIFT on a sel falling edge; SHIFT -> UPDATE on a sel rising edge with bit count = 16; SHIFT -> IDLE on a sel rising edge with bit count != 16 (frame_err); UPDATE -> IDLE after 1 clk.
REQ-013 SHALL shift synchronised din into a 16-bit receive register (LSB in, MSB first) on each sclk falling edge in SHIFT.
REQ-014 SHALL count received bits with a 5-bit saturating counter that clears on the sel falling edge.
REQ-015 SHALL ignore bits beyond 16; a count > 16 SHALL produce frame_err, leave the registers unchanged and raise no frame_done.
REQ-016 SHALL decode the frame as word[15:12] = cmd, word[11:2] = 10-bit value, word[1:0] = ignored.
REQ-017 SHALL execute commands in UPDATE:
- cmd 0-7: write the value to channel cmd.
- cmd 8: write the value to all channels.
- cmd 9: clear all channels to 0.
- cmd 10-15: no register change; frame_done and last_cmd still update.
REQ-018 SHALL assert frame_done in the UPDATE cycle and load last_cmd in the same cycle.
REQ-019 SHALL drive dac_dout from the MSB of a 16-bit echo register. That register shifts at each sclk rising edge in SHIFT and holds the previous accepted frame, so the bit on dout equals the din bit received 16 sclk periods earlier.
REQ-020 SHALL load the echo register with the receive register on UPDATE and SHALL NOT change it after an errored frame.
REQ-021 SHALL hold dac_dout high while in IDLE.
REQ-022 SHALL ignore sclk edges while dac_sel is synchronised high.
REQ-023 SHALL treat a sel falling edge occurring in UPDATE as a new frame start in the following cycle, with no lost bits (minimum sel-high time is one sclk period).

Reset
REQ-024 SHALL, on reset low, clear immediately: FSM = IDLE; bit counter = 0; receive register = 0; echo register = 16'hFFFF; ch_value = 0; last_cmd = 0; frame_done = 0; frame_err = 0; dac_dout = 1.
REQ-025 SHALL, after reset deasserts mid-frame, wait for the next sel falling edge before shifting bits.

Configuration
REQ-026 SHALL support the macro HV_DAC_SLAVE_LDAC_EN.
- When defined: add input ldac_n (1 bit, asynchronous, 2-FF synchronised, active-low). Commands write a staging bank. ch_value updates from staging on each synchronised ldac_n falling edge. If that edge coincides with UPDATE, the transfer includes the new write.
- When undefined: there is no ldac_n and ch_value updates directly in UPDATE.

Structure
REQ-027 SHALL place in shared package hv_dac_pkg: the frame width (16), value width (10), channel count (8), command codes CMD_BCAST = 8 and CMD_CLR = 9, and the FSM state enum.
REQ-028 SHALL use one sub-module, sync_edge_det (2-FF synchroniser plus rise/fall pulse outputs), instantiated once for each of sel, sclk and ldac_n.

Verification
REQ-029 Frame 16'h3A5C (cmd 3, value 0x297) -> ch3 = 0x297, other channels 0, one frame_done, last_cmd = 3.
REQ-030 Frame 16'h8004 then 16'h9000 -> all channels = 0x001, then all channels = 0.
REQ-031 Frame of 15 bits, then a frame of 17 bits -> frame_err pulses twice, ch_value unchanged, no frame_done.
REQ-032 Frame A = 16'h1234 then frame B -> during B, dac_dout serialises 16'h1234 MSB first; after reset, dout = 1 for the whole first frame.
REQ-033 Reset asserted at bit 8 of a frame -> all outputs at reset values; next complete frame is accepted correctly.
REQ-034 With HV_DAC_SLAVE_LDAC_EN: write ch5 = 0x3FF -> ch_value unchanged until an ldac_n pulse, then ch5 = 0x3FF.

Source files
------------

// File: rtl/hv_dac_pkg.sv
// Shared constants, frame decode helpers and FSM encoding for the HV DAC serial slave.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hv_dac_pkg;

    localparam int FRAME_W = 16;
    localparam int VAL_W   = 10;
    localparam int CH_N    = 8;
    localparam int CMD_W   = 4;
    localparam int CNT_W   = 5;

    // Bit count that makes a frame valid, and the saturation ceiling of the counter.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [CMD_W-1:0] CMD_BCAST = 4'd8;
    localparam logic [CMD_W-1:0] CMD_CLR   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    // Channel n sits at bits [10n+9:10n] of the flattened bank.
    typedef logic [CH_N-1:0][VAL_W-1:0] ch_bank_t;

    // Returns the channel bank after executing one decoded command.
    // Commands above CMD_CLR leave the bank untouched.
    function automatic ch_bank_t apply_cmd(input ch_bank_t bank,
                                           input logic [CMD_W-1:0] cmd,
                                           input logic [VAL_W-1:0] value);
        ch_bank_t r;
        r = bank;
        if (cmd < CMD_BCAST) begin
            r[cmd[2:0]] = value;
        end else if (cmd == CMD_BCAST) begin
            r = {CH_N{value}};
        end else if (cmd == CMD_CLR) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/hv_dac_slave_if.sv
// Serial DAC bus: active-low frame select, serial clock, data in and echo data out.
// Latency: n/a (wiring only).
// Backpressure: none; the master owns the bus timing.
interface hv_dac_slave_if;

    logic dac_sel;
    logic dac_sclk;
    logic dac_din;
    logic dac_dout;

    modport master (
        output dac_sel,
        output dac_sclk,
        output dac_din,
        input  dac_dout
    );

    modport slave (
        input  dac_sel,
        input  dac_sclk,
        input  dac_din,
        output dac_dout
    );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level with single-cycle rise/fall pulses.
// Latency: an input edge shows up as a pulse 2-3 clk later.
// Backpressure: none; edges are reported, never held.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic       s1;
    logic       s2;
    logic       s3;
    logic [1:0] warm;
    logic       armed;

    // Two synchroniser stages plus one history flop used to spot transitions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Hold off edge reporting until the pipeline carries real samples, so a
    // line already sitting low when reset releases is not seen as a new edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warm <= 2'd0;
        end else if (warm != 2'd3) begin
            warm <= warm + 2'd1;
        end
    end

    assign armed = (warm == 2'd3);
    assign rise  = armed &  s2 & ~s3;
    assign fall  = armed & ~s2 &  s3;

endmodule

// File: rtl/hv_dac_slave.sv
// 8-channel x 10-bit DAC register slave on a 16-bit serial frame bus, echoing the previous frame on dout.
// Latency: registers update one clk after the frame-closing sel rise is synchronised (about 4 clk).
// Backpressure: none; optional HV_DAC_SLAVE_LDAC_EN adds ldac_n to load outputs from a staging bank.
module hv_dac_slave
    import hv_dac_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
`ifdef HV_DAC_SLAVE_LDAC_EN
    input  logic                  ldac_n,
`endif
    hv_dac_slave_if.slave         bus,
    output logic [CH_N*VAL_W-1:0] ch_value,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [CMD_W-1:0]      last_cmd
);

    state_t               state;
    state_t               state_nxt;
    logic                 frame_start;

    logic                 sel_rise;
    logic                 sel_fall;
    logic                 sclk_rise;
    logic                 sclk_fall;
    logic                 din_s1;
    logic                 din_s2;

    logic [CNT_W-1:0]     cnt;
    logic [FRAME_W-1:0]   rx;
    logic [FRAME_W-1:0]   echo;
    logic [FRAME_W-1:0]   accepted;

    logic [CMD_W-1:0]     rx_cmd;
    logic [VAL_W-1:0]     rx_value;
    ch_bank_t             stage;
    ch_bank_t             stage_nxt;

    sync_edge_det #(.RST_VAL(1'b1)) u_sel_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.dac_sel),
        .rise  (sel_rise),
        .fall  (sel_fall)
    );

    sync_edge_det #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.dac_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Data needs only the level, aligned with the sclk edge pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_s1 <= 1'b0;
            din_s2 <= 1'b0;
        end else begin
            din_s1 <= bus.dac_din;
            din_s2 <= din_s1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and frame status pulses. SHIFT is only ever occupied while sel
    // is synchronised low, so gating sclk edges on SHIFT also ignores them
    // while sel is high. A sel fall during UPDATE starts the next frame at once.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        frame_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_fall) begin
                    state_nxt   = ST_SHIFT;
                    frame_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (sel_rise) begin
                    if (cnt == CNT_FULL) begin
                        state_nxt = ST_UPDATE;
                    end else begin
                        state_nxt = ST_IDLE;
                        frame_err = 1'b1;
                    end
                end
            end
            ST_UPDATE: begin
                frame_done = 1'b1;
                if (sel_fall) begin
                    state_nxt   = ST_SHIFT;
                    frame_start = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Saturating bit counter and receive shifter; bits past the 16th only count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            rx  <= '0;
        end else if (frame_start) begin
            cnt <= '0;
        end else if (state == ST_SHIFT && sclk_fall) begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (cnt < CNT_FULL) begin
                rx <= {rx[FRAME_W-2:0], din_s2};
            end
        end
    end

    // Echo path: 'accepted' keeps the last good frame; 'echo' is the working
    // copy shifted out on dout. Reloading echo from accepted at every frame
    // start discards any shifting done during an errored frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accepted <= '1;
            echo     <= '1;
        end else if (state == ST_UPDATE) begin
            accepted <= rx;
            echo     <= rx;
        end else if (frame_start) begin
            echo <= accepted;
        end else if (state == ST_SHIFT && sclk_rise) begin
            echo <= {echo[FRAME_W-2:0], 1'b1};
        end
    end

    assign bus.dac_dout = (state == ST_IDLE) ? 1'b1 : echo[FRAME_W-1];

    assign rx_cmd    = rx[FRAME_W-1 -: CMD_W];
    assign rx_value  = rx[FRAME_W-1-CMD_W -: VAL_W];
    assign stage_nxt = (state == ST_UPDATE) ? apply_cmd(stage, rx_cmd, rx_value) : stage;

    // Command execution into the channel bank and last-command capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage    <= '0;
            last_cmd <= '0;
        end else begin
            stage <= stage_nxt;
            if (state == ST_UPDATE) begin
                last_cmd <= rx_cmd;
            end
        end
    end

`ifdef HV_DAC_SLAVE_LDAC_EN
    logic     ldac_rise;
    logic     ldac_fall;
    ch_bank_t live;

    sync_edge_det #(.RST_VAL(1'b1)) u_ldac_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ldac_n),
        .rise  (ldac_rise),
        .fall  (ldac_fall)
    );

    // Output bank loads from staging on ldac_n falling; taking stage_nxt means
    // a write executing in the same cycle is included in the transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live <= '0;
        end else if (ldac_fall) begin
            live <= stage_nxt;
        end
    end

    assign ch_value = live;
`else
    assign ch_value = stage;
`endif

endmodule
